// File: rtl/multi_digit_display_driver_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
// Holds the active-low segment patterns (bit 0 = segment a, bit 6 = g)
// and the bit positions used to assemble the 8-bit SEG_N output.
package multi_digit_display_driver_pkg;

    typedef logic [6:0] seg7_t;

    localparam int unsigned SEG_NUM_BITS = 7;  // segments a..g
    localparam int unsigned SEG_DP_BIT   = 7;  // decimal point within SEG_N

    localparam seg7_t SEG_0   = 7'h40;
    localparam seg7_t SEG_1   = 7'h79;
    localparam seg7_t SEG_2   = 7'h24;
    localparam seg7_t SEG_3   = 7'h30;
    localparam seg7_t SEG_4   = 7'h19;
    localparam seg7_t SEG_5   = 7'h12;
    localparam seg7_t SEG_6   = 7'h02;
    localparam seg7_t SEG_7   = 7'h78;
    localparam seg7_t SEG_8   = 7'h00;
    localparam seg7_t SEG_9   = 7'h10;
    localparam seg7_t SEG_A   = 7'h08;
    localparam seg7_t SEG_B   = 7'h03;
    localparam seg7_t SEG_C   = 7'h46;
    localparam seg7_t SEG_D   = 7'h21;
    localparam seg7_t SEG_E   = 7'h06;
    localparam seg7_t SEG_F   = 7'h0E;
    localparam seg7_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/multi_digit_display_driver_if.sv
// Bus between a datapath and the display driver.
//   value        hex nibbles, digit 0 = value[3:0] (rightmost)
//   dots         per-digit decimal point, 1 = lit
//   load         1-cycle strobe capturing value/dots
//   lz_suppress  1 = blank leading zero digits
//   brightness   on-time duty, 0 = dark, 15 = full
//   seg_n        [6:0] = g..a, [7] = dp, active-low
//   an_n         digit enables, active-low, one-cold
//   update_pend  captured data waiting for the frame boundary
//   frame_tick   1-cycle pulse as the digit index wraps to 0
// master drives the controls (datapath side), slave is the driver.
interface multi_digit_display_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dots;
    logic                    load;
    logic                    lz_suppress;
    logic [3:0]              brightness;
    logic [7:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    update_pend;
    logic                    frame_tick;

    modport master (
        output value, dots, load, lz_suppress, brightness,
        input  seg_n, an_n, update_pend, frame_tick
    );

    modport slave (
        input  value, dots, load, lz_suppress, brightness,
        output seg_n, an_n, update_pend, frame_tick
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   i_nibble  4-bit hex digit
//   o_seg     segments g..a, active-low (bit 0 = a)
module hex_to_seg7
    import multi_digit_display_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7_t      o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        unique case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/multi_digit_display_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Scans one digit per REFRESH_DIV-cycle slot, blanks the first BLANK_CYCLES
// of each slot against ghosting, scales the on-window by brightness, and
// swaps newly loaded data in only at the frame boundary.
//   i_clk     system clock, rising edge
//   i_resetn  synchronous reset, active-low
//   io_disp   control/display bus (slave side), see the interface file
module multi_digit_display_driver
    import multi_digit_display_driver_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                          i_clk,
    input  logic                          i_resetn,
    multi_digit_display_driver_if.slave   io_disp
);

    localparam int unsigned CntW   = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
    localparam int unsigned ValW   = 4 * NUM_DIGITS;
    localparam int unsigned OnSpan = REFRESH_DIV - BLANK_CYCLES;

    logic [CntW-1:0]       r_cnt;
    logic [IdxW-1:0]       r_idx;
    logic [ValW-1:0]       r_act_value;
    logic [NUM_DIGITS-1:0] r_act_dots;
    logic [ValW-1:0]       r_pend_value;
    logic [NUM_DIGITS-1:0] r_pend_dots;
    logic                  r_pend;
    logic [7:0]            r_seg_n;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic                  r_frame_tick;

    logic                  w_slot_end;
    logic                  w_boundary;
    logic [31:0]           w_cnt_ext;
    logic [31:0]           w_on_len;
    logic                  w_an_on;
    logic [3:0]            w_nibble;
    logic                  w_dot;
    seg7_t                 w_dec;
    logic                  w_zero_run;
    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic                  w_blank;
    logic [7:0]            w_seg_next;
    logic [NUM_DIGITS-1:0] w_an_next;

    assign w_slot_end = (r_cnt == CntW'(REFRESH_DIV - 1));
    assign w_boundary = w_slot_end && (r_idx == IdxW'(NUM_DIGITS - 1));

    // Lit window: starts after the blanking gap, length scaled by brightness/16;
    // full brightness forces the whole remaining slot on.
    assign w_cnt_ext = 32'(r_cnt);
    assign w_on_len  = (OnSpan * 32'(io_disp.brightness)) >> 4;
    assign w_an_on   = (w_cnt_ext >= BLANK_CYCLES) &&
                       ((io_disp.brightness == 4'hF) ||
                        ((w_cnt_ext - BLANK_CYCLES) < w_on_len));

    assign w_nibble = r_act_value[4*int'(r_idx) +: 4];
    assign w_dot    = r_act_dots[r_idx];

    hex_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec)
    );

    // Digit k is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_lz_blank = '0;
        w_zero_run = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            w_zero_run    = w_zero_run && (r_act_value[4*k +: 4] == 4'h0);
            w_lz_blank[k] = w_zero_run;
        end
    end

    assign w_blank = io_disp.lz_suppress && w_lz_blank[r_idx];

    always_comb begin
        w_seg_next = 8'hFF;
        w_an_next  = '1;
        if (w_an_on) begin
            w_seg_next[SEG_NUM_BITS-1:0] = w_blank ? SEG_OFF : w_dec;
            w_seg_next[SEG_DP_BIT]       = ~w_dot;
            w_an_next[r_idx]             = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_act_value  <= '0;
            r_act_dots   <= '0;
            r_pend_value <= '0;
            r_pend_dots  <= '0;
            r_pend       <= 1'b0;
            r_seg_n      <= 8'hFF;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) begin
                r_idx <= w_boundary ? '0 : r_idx + 1'b1;
            end
            r_frame_tick <= w_boundary;
            r_seg_n      <= w_seg_next;
            r_an_n       <= w_an_next;

            if (w_boundary) begin
                // A load on the boundary itself bypasses the pending stage.
                if (io_disp.load) begin
                    r_act_value <= io_disp.value;
                    r_act_dots  <= io_disp.dots;
                end else if (r_pend) begin
                    r_act_value <= r_pend_value;
                    r_act_dots  <= r_pend_dots;
                end
                r_pend <= 1'b0;
            end else if (io_disp.load) begin
                r_pend_value <= io_disp.value;
                r_pend_dots  <= io_disp.dots;
                r_pend       <= 1'b1;
            end
        end
    end

    assign io_disp.seg_n       = r_seg_n;
    assign io_disp.an_n        = r_an_n;
    assign io_disp.update_pend = r_pend;
    assign io_disp.frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_multi_digit_display_driver.sv
module tb_multi_digit_display_driver;

    localparam int unsigned NumDigits   = 4;
    localparam int unsigned RefreshDiv  = 8;
    localparam int unsigned BlankCycles = 2;
    localparam int          FrameLen    = 32;
    localparam int          NumVecs     = 9;

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dots;
        logic             lz;
        logic [3:0]       br;
        logic [3:0][7:0]  seg;  // expected SEG_N per digit while lit, FF if never lit
        int               lit;  // expected lit cycles per slot
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    multi_digit_display_driver_if #(.NUM_DIGITS(NumDigits)) u_if ();

    multi_digit_display_driver #(
        .NUM_DIGITS   (NumDigits),
        .REFRESH_DIV  (RefreshDiv),
        .BLANK_CYCLES (BlankCycles)
    ) u_dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .io_disp  (u_if)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [NumVecs];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FrameLen; i++) begin
            @(negedge clk);
            if (u_if.frame_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic drive_load(input vec_t v);
        u_if.value       = v.value;
        u_if.dots        = v.dots;
        u_if.lz_suppress = v.lz;
        u_if.brightness  = v.br;
        u_if.load        = 1'b1;
        @(negedge clk);
        u_if.load        = 1'b0;
    endtask

    // Call right at the negedge where frame_tick was seen: the next 32 samples
    // are slots 0..3, counter 0..7 each.
    task automatic observe_frame(input vec_t v, input string tag);
        int         lit [NumDigits];
        logic [7:0] cap [NumDigits];
        int         bad = 0;
        for (int d = 0; d < int'(NumDigits); d++) begin
            lit[d] = 0;
            cap[d] = 8'hFF;
        end
        for (int j = 0; j < FrameLen; j++) begin
            int         d = j / int'(RefreshDiv);
            logic [3:0] one_cold;
            @(negedge clk);
            one_cold    = 4'hF;
            one_cold[d] = 1'b0;
            if (u_if.update_pend !== 1'b0) bad++;
            if (u_if.an_n === 4'hF) begin
                if (u_if.seg_n !== 8'hFF) bad++;
            end else if (u_if.an_n === one_cold) begin
                lit[d]++;
                cap[d] = u_if.seg_n;
            end else begin
                bad++;
            end
        end
        for (int d = 0; d < int'(NumDigits); d++) begin
            check($sformatf("%s_seg_d%0d", tag, d), 32'(cap[d]), 32'(v.seg[d]));
            check($sformatf("%s_lit_d%0d", tag, d), 32'(lit[d]), 32'(v.lit));
        end
        check($sformatf("%s_glitches", tag), 32'(bad), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   bad;

        vecs[0] = '{16'h12AF, 4'b0100, 1'b0, 4'd15, {8'hF9, 8'h24, 8'h88, 8'h8E}, 6};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, 4'd15, {8'hFF, 8'hFF, 8'hFF, 8'h92}, 6};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'd15, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 6};
        vecs[3] = '{16'h0000, 4'b1000, 1'b1, 4'd15, {8'h7F, 8'hFF, 8'hFF, 8'hC0}, 6};
        vecs[4] = '{16'h3456, 4'b0000, 1'b0, 4'd0,  {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0};
        vecs[5] = '{16'h789C, 4'b1111, 1'b0, 4'd8,  {8'h78, 8'h00, 8'h10, 8'h46}, 3};
        vecs[6] = '{16'hDE0B, 4'b0000, 1'b1, 4'd3,  {8'hA1, 8'h86, 8'hC0, 8'h83}, 1};
        vecs[7] = '{16'h0100, 4'b0000, 1'b1, 4'd14, {8'hFF, 8'hF9, 8'hC0, 8'hC0}, 5};
        vecs[8] = '{16'hFFFF, 4'b0000, 1'b0, 4'd1,  {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0};

        u_if.value       = '0;
        u_if.dots        = '0;
        u_if.load        = 1'b0;
        u_if.lz_suppress = 1'b0;
        u_if.brightness  = 4'd15;
        resetn           = 1'b0;

        // Reset state and first lit cycle
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(u_if.seg_n), 32'hFF);
        check("rst_an", 32'(u_if.an_n), 32'hF);
        check("rst_pend", 32'(u_if.update_pend), 32'd0);
        check("rst_tick", 32'(u_if.frame_tick), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rel_an_c1", 32'(u_if.an_n), 32'hF);
        @(negedge clk);
        check("rel_an_c2", 32'(u_if.an_n), 32'hF);
        @(negedge clk);
        check("rel_an_c3", 32'(u_if.an_n), 32'hE);
        check("rel_seg_c3", 32'(u_if.seg_n), 32'hC0);

        // Table-driven frames
        for (int i = 0; i < NumVecs; i++) begin
            wait_tick($sformatf("v%0d_sync", i));
            drive_load(vecs[i]);
            check($sformatf("v%0d_pend_set", i), 32'(u_if.update_pend), 32'd1);
            wait_tick($sformatf("v%0d_tick", i));
            check($sformatf("v%0d_pend_clr", i), 32'(u_if.update_pend), 32'd0);
            observe_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Two loads in one frame: old value held, last capture wins
        wait_tick("ml_sync");
        repeat (5) @(negedge clk);
        v = '{16'h1234, 4'b0000, 1'b0, 4'd15, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 6};
        drive_load(v);
        check("ml_pend1", 32'(u_if.update_pend), 32'd1);
        repeat (3) @(negedge clk);
        v = '{16'h0005, 4'b0000, 1'b0, 4'd15, {8'hC0, 8'hC0, 8'hC0, 8'h92}, 6};
        drive_load(v);
        check("ml_pend2", 32'(u_if.update_pend), 32'd1);
        bad = 0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 2 * FrameLen; i++) begin
                @(negedge clk);
                if (u_if.frame_tick === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                if (u_if.update_pend !== 1'b1) bad++;
                if (u_if.an_n !== 4'hF && u_if.seg_n !== 8'h8E) bad++;
            end
            check("ml_tick", 32'(seen), 32'd1);
        end
        check("ml_old_held", 32'(bad), 32'd0);
        check("ml_pend_clr", 32'(u_if.update_pend), 32'd0);
        observe_frame(v, "ml");

        // Load exactly on the boundary cycle: no pending phase
        wait_tick("bd_sync");
        repeat (FrameLen - 1) @(negedge clk);
        v = '{16'hA5C3, 4'b0001, 1'b0, 4'd8, {8'h88, 8'h92, 8'hC6, 8'h30}, 3};
        u_if.value       = v.value;
        u_if.dots        = v.dots;
        u_if.lz_suppress = v.lz;
        u_if.brightness  = v.br;
        u_if.load        = 1'b1;
        @(negedge clk);
        u_if.load = 1'b0;
        check("bd_tick", 32'(u_if.frame_tick), 32'd1);
        check("bd_no_pend", 32'(u_if.update_pend), 32'd0);
        observe_frame(v, "bd");

        // Reset mid-slot drops pending data
        wait_tick("mr_sync");
        u_if.brightness = 4'd15;
        repeat (3) @(negedge clk);
        v = '{16'h7777, 4'b1111, 1'b0, 4'd15, {8'h78, 8'h78, 8'h78, 8'h78}, 6};
        drive_load(v);
        check("mr_pend", 32'(u_if.update_pend), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("mr_seg", 32'(u_if.seg_n), 32'hFF);
        check("mr_an", 32'(u_if.an_n), 32'hF);
        check("mr_pend_lost", 32'(u_if.update_pend), 32'd0);
        check("mr_tick", 32'(u_if.frame_tick), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("mr_an_c3", 32'(u_if.an_n), 32'hE);
        check("mr_seg_c3", 32'(u_if.seg_n), 32'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
